// File: rtl/div_issue_pkg.sv
// Shared types and constants for the divide issue stage.
// Opcode values match funct3 of the M-extension divide group.
package div_issue_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;

    typedef logic [REG_W-1:0]  reg_t;
    typedef logic [ADDR_W-1:0] raddr_t;
    typedef logic [2:0]        op_t;

    localparam op_t  INST_DIV  = 3'b100;
    localparam op_t  INST_DIVU = 3'b101;
    localparam op_t  INST_REM  = 3'b110;
    localparam op_t  INST_REMU = 3'b111;
    localparam reg_t ZERO_WORD = '0;

    localparam int IDLE_B   = 0;
    localparam int WAIT_B   = 1;
    localparam int DONE_B   = 2;
    localparam int CANCEL_B = 3;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_WAIT   = 4'b0010,
        S_DONE   = 4'b0100,
        S_CANCEL = 4'b1000
    } state_e;

    typedef struct packed {
        op_t    op;
        reg_t   dividend;
        reg_t   divisor;
        raddr_t waddr;
    } div_req_t;

endpackage

// File: rtl/div_issue_if.sv
// Handshake bundle between the issue stage and the divider.
// master = issue side, slave = divider side.
interface div_issue_if;
    import div_issue_pkg::*;

    logic   div_start_o;
    reg_t   div_dividend_o;
    reg_t   div_divisor_o;
    op_t    div_op_o;
    raddr_t div_reg_waddr_o;
    reg_t   div_result_i;
    logic   div_ready_i;
    logic   div_busy_i;

    modport master (
        output div_start_o,
        output div_dividend_o,
        output div_divisor_o,
        output div_op_o,
        output div_reg_waddr_o,
        input  div_result_i,
        input  div_ready_i,
        input  div_busy_i
    );

    modport slave (
        input  div_start_o,
        input  div_dividend_o,
        input  div_divisor_o,
        input  div_op_o,
        input  div_reg_waddr_o,
        output div_result_i,
        output div_ready_i,
        output div_busy_i
    );

endinterface

// File: rtl/div_issue.sv
// Issues one divide to the external divider, stalls EX meanwhile,
// and writes the quotient/remainder back for a single cycle.
module div_issue
    import div_issue_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req_i,
    input  op_t          op_i,
    input  reg_t         reg1_rdata_i,
    input  reg_t         reg2_rdata_i,
    input  raddr_t       reg_waddr_i,
    input  logic         flush_i,
    div_issue_if.master  div,
    output logic         hold_o,
    output logic         reg_we_o,
    output raddr_t       reg_waddr_o,
    output reg_t         reg_wdata_o
);

    state_e   state_q, state_d;
    div_req_t req_q, req_d;
    reg_t     result_q, result_d;

    logic st_idle, st_wait, st_done, st_cancel;
    logic capture, finish;

    assign st_idle   = state_q[IDLE_B];
    assign st_wait   = state_q[WAIT_B];
    assign st_done   = state_q[DONE_B];
    assign st_cancel = state_q[CANCEL_B];

    assign capture = st_idle & req_i & ~flush_i;
    assign finish  = st_wait & div.div_ready_i & ~flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush outranks a same-cycle ready: the result is dropped.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q[IDLE_B]: begin
                if (req_i && !flush_i) state_d = S_WAIT;
            end
            state_q[WAIT_B]: begin
                if (flush_i)               state_d = S_CANCEL;
                else if (div.div_ready_i)  state_d = S_DONE;
            end
            state_q[DONE_B]: begin
                state_d = S_IDLE;
            end
            state_q[CANCEL_B]: begin
                if (!div.div_busy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_d    = req_q;
        result_d = result_q;
        if (capture) begin
            req_d.op       = op_i;
            req_d.dividend = reg1_rdata_i;
            req_d.divisor  = reg2_rdata_i;
            req_d.waddr    = reg_waddr_i;
        end
        if (finish) result_d = div.div_result_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q    <= '0;
            result_q <= ZERO_WORD;
        end else begin
            req_q    <= req_d;
            result_q <= result_d;
        end
    end

    // Start drops combinationally on ready so the divider cannot relaunch.
    always_comb begin
        div.div_start_o     = 1'b0;
        div.div_dividend_o  = ZERO_WORD;
        div.div_divisor_o   = ZERO_WORD;
        div.div_op_o        = '0;
        div.div_reg_waddr_o = '0;
        hold_o              = 1'b0;
        reg_we_o            = 1'b0;
        reg_waddr_o         = '0;
        reg_wdata_o         = ZERO_WORD;
        unique case (1'b1)
            st_idle: begin
                hold_o = rst & req_i & ~flush_i;
            end
            st_wait: begin
                div.div_start_o     = ~div.div_ready_i & ~flush_i;
                div.div_dividend_o  = req_q.dividend;
                div.div_divisor_o   = req_q.divisor;
                div.div_op_o        = req_q.op;
                div.div_reg_waddr_o = req_q.waddr;
                hold_o              = 1'b1;
            end
            st_done: begin
                reg_we_o    = 1'b1;
                reg_waddr_o = req_q.waddr;
                reg_wdata_o = result_q;
            end
            st_cancel: begin
                hold_o = req_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a fixed-latency divider model.
module tb_div_issue;
    import div_issue_pkg::*;

    localparam int LAT = 16;

    logic   clk = 1'b0;
    logic   rst;
    logic   req_i;
    op_t    op_i;
    reg_t   reg1_rdata_i, reg2_rdata_i;
    raddr_t reg_waddr_i;
    logic   flush_i;
    logic   hold_o, reg_we_o;
    raddr_t reg_waddr_o;
    reg_t   reg_wdata_o;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    div_issue_if dif();

    div_issue dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .op_i         (op_i),
        .reg1_rdata_i (reg1_rdata_i),
        .reg2_rdata_i (reg2_rdata_i),
        .reg_waddr_i  (reg_waddr_i),
        .flush_i      (flush_i),
        .div          (dif),
        .hold_o       (hold_o),
        .reg_we_o     (reg_we_o),
        .reg_waddr_o  (reg_waddr_o),
        .reg_wdata_o  (reg_wdata_o)
    );

    always #5 clk = ~clk;

    function automatic reg_t dmodel(op_t op, reg_t a, reg_t b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            INST_DIV: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == '1) return a;
                return sa / sb;
            end
            INST_DIVU: return (b == 0) ? '1 : a / b;
            INST_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == '1) return '0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    logic [4:0] d_cnt;
    reg_t       d_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dif.div_busy_i   <= 1'b0;
            dif.div_ready_i  <= 1'b0;
            dif.div_result_i <= '0;
            d_cnt            <= '0;
            d_res            <= '0;
        end else begin
            dif.div_ready_i  <= 1'b0;
            dif.div_result_i <= '0;
            if (dif.div_start_o && !dif.div_busy_i) begin
                dif.div_busy_i <= 1'b1;
                d_cnt          <= 5'(LAT);
                d_res          <= dmodel(dif.div_op_o,
                                         dif.div_dividend_o,
                                         dif.div_divisor_o);
            end else if (dif.div_busy_i) begin
                if (d_cnt == 5'd1) begin
                    dif.div_busy_i   <= 1'b0;
                    dif.div_ready_i  <= 1'b1;
                    dif.div_result_i <= d_res;
                end else begin
                    d_cnt <= d_cnt - 5'd1;
                end
            end
        end
    end

    always @(posedge clk)
        if (rst === 1'b1 && dif.div_start_o === 1'b1
            && dif.div_ready_i === 1'b1)
            viol <= viol + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_i        = 1'b0;
        op_i         = '0;
        reg1_rdata_i = '0;
        reg2_rdata_i = '0;
        reg_waddr_i  = '0;
    endtask

    task automatic run_op(input string nm, input op_t op,
                          input reg_t a, input reg_t b,
                          input raddr_t wa, input reg_t exp);
        int n;
        bit got, hold_bad;
        req_i = 1'b1; op_i = op;
        reg1_rdata_i = a; reg2_rdata_i = b; reg_waddr_i = wa;
        #1;
        checks++;
        if (hold_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_hold_req got %b want 1", nm, hold_o);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (dif.div_start_o !== 1'b1 || dif.div_dividend_o !== a
            || dif.div_divisor_o !== b || dif.div_op_o !== op
            || dif.div_reg_waddr_o !== wa) begin
            errors++;
            $display("FAIL %s_launch got st=%b a=%h b=%h op=%h wa=%0d want 1 %h %h %h %0d",
                     nm, dif.div_start_o, dif.div_dividend_o,
                     dif.div_divisor_o, dif.div_op_o,
                     dif.div_reg_waddr_o, a, b, op, wa);
        end
        n = 0; got = 0; hold_bad = 0;
        while (!got && n < 200) begin
            if (reg_we_o === 1'b1) got = 1;
            else begin
                if (hold_o !== 1'b1) hold_bad = 1;
                tick(); #1; n++;
            end
        end
        checks++;
        if (!got || n != LAT + 2) begin
            errors++;
            $display("FAIL %s_latency got %0d got_we %0b want %0d",
                     nm, n, got, LAT + 2);
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL %s_hold_wait got dropout want steady 1", nm);
        end
        checks++;
        if (reg_wdata_o !== exp || reg_waddr_o !== wa
            || hold_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_wb got wd=%h wa=%0d hold=%b want %h %0d 0",
                     nm, reg_wdata_o, reg_waddr_o, hold_o, exp, wa);
        end
        tick(); #1;
        checks++;
        if (reg_we_o !== 1'b0 || reg_wdata_o !== '0
            || reg_waddr_o !== '0) begin
            errors++;
            $display("FAIL %s_pulse got we=%b wd=%h wa=%0d want 0 0 0",
                     nm, reg_we_o, reg_wdata_o, reg_waddr_o);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        flush_i = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dif.div_start_o !== 1'b0 || hold_o !== 1'b0
            || reg_we_o !== 1'b0 || reg_wdata_o !== '0
            || reg_waddr_o !== '0 || dif.div_dividend_o !== '0) begin
            errors++;
            $display("FAIL reset_outs got st=%b h=%b we=%b wd=%h wa=%0d dv=%h want all 0",
                     dif.div_start_o, hold_o, reg_we_o, reg_wdata_o,
                     reg_waddr_o, dif.div_dividend_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_op("div_7_2", INST_DIV, 32'd7, 32'd2, 5'd5, 32'h3);
    endtask

    task automatic test_ops;
        run_op("rem_m7_2", INST_REM, 32'hFFFF_FFF9, 32'd2,
               5'd6, 32'hFFFF_FFFF);
        run_op("divu_9_0", INST_DIVU, 32'd9, 32'd0,
               5'd12, 32'hFFFF_FFFF);
        run_op("remu_9_0", INST_REMU, 32'd9, 32'd0,
               5'd13, 32'h9);
    endtask

    task automatic test_flush;
        int n;
        bit bad;
        req_i = 1'b1; op_i = INST_DIV;
        reg1_rdata_i = 32'd100; reg2_rdata_i = 32'd3; reg_waddr_i = 5'd7;
        tick();
        idle_inputs();
        repeat (10) tick();
        flush_i = 1'b1;
        #1;
        checks++;
        if (dif.div_start_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_start got %b want 0", dif.div_start_o);
        end
        tick();
        flush_i = 1'b0;
        req_i = 1'b1; op_i = INST_DIV;
        reg1_rdata_i = 32'd40; reg2_rdata_i = 32'd4; reg_waddr_i = 5'd8;
        #1;
        checks++;
        if (hold_o !== 1'b1 || dif.div_start_o !== 1'b0
            || reg_we_o !== 1'b0) begin
            errors++;
            $display("FAIL cancel_entry got h=%b st=%b we=%b want 1 0 0",
                     hold_o, dif.div_start_o, reg_we_o);
        end
        n = 0; bad = 0;
        tick();
        flush_i = 1'b1;
        #1;
        while (dif.div_busy_i === 1'b1 && n < 100) begin
            if (hold_o !== 1'b1 || dif.div_start_o !== 1'b0
                || reg_we_o !== 1'b0) bad = 1;
            tick(); #1; n++;
        end
        checks++;
        if (bad || n >= 100 || hold_o !== 1'b1) begin
            errors++;
            $display("FAIL cancel_hold got bad=%0b n=%0d h=%b want 0 <100 1",
                     bad, n, hold_o);
        end
        tick(); #1;
        checks++;
        if (hold_o !== 1'b0 || dif.div_start_o !== 1'b0) begin
            errors++;
            $display("FAIL cancel_exit got h=%b st=%b want 0 0",
                     hold_o, dif.div_start_o);
        end
        flush_i = 1'b0;
        idle_inputs();
        tick(); #1;
        checks++;
        if (dif.div_start_o !== 1'b0 || reg_we_o !== 1'b0) begin
            errors++;
            $display("FAIL cancel_nocap got st=%b we=%b want 0 0",
                     dif.div_start_o, reg_we_o);
        end
        run_op("div_8_4", INST_DIV, 32'd8, 32'd4, 5'd9, 32'h2);
    endtask

    task automatic test_flush_ready;
        int n;
        req_i = 1'b1; op_i = INST_DIVU;
        reg1_rdata_i = 32'd20; reg2_rdata_i = 32'd4; reg_waddr_i = 5'd14;
        tick();
        idle_inputs();
        n = 0;
        while (dif.div_ready_i !== 1'b1 && n < 100) begin
            tick(); n++;
        end
        flush_i = 1'b1;
        #1;
        checks++;
        if (n >= 100 || reg_we_o !== 1'b0 || dif.div_start_o !== 1'b0) begin
            errors++;
            $display("FAIL fr_same got n=%0d we=%b st=%b want <100 0 0",
                     n, reg_we_o, dif.div_start_o);
        end
        tick();
        flush_i = 1'b0;
        #1;
        checks++;
        if (reg_we_o !== 1'b0) begin
            errors++;
            $display("FAIL fr_nowb got we=%b want 0", reg_we_o);
        end
        tick();
        req_i = 1'b1; flush_i = 1'b1;
        #1;
        checks++;
        if (hold_o !== 1'b0 || reg_we_o !== 1'b0) begin
            errors++;
            $display("FAIL fr_idle got h=%b we=%b want 0 0",
                     hold_o, reg_we_o);
        end
        tick();
        req_i = 1'b0; flush_i = 1'b0;
        #1;
        checks++;
        if (dif.div_start_o !== 1'b0 || hold_o !== 1'b0) begin
            errors++;
            $display("FAIL fr_ignore got st=%b h=%b want 0 0",
                     dif.div_start_o, hold_o);
        end
    endtask

    task automatic test_back_to_back;
        run_op("b2b_100_10", INST_DIVU, 32'd100, 32'd10, 5'd10, 32'hA);
        run_op("b2b_50_5", INST_DIVU, 32'd50, 32'd5, 5'd11, 32'hA);
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL start_on_ready got %0d want 0", viol);
        end
    endtask

    task automatic test_reset_mid;
        req_i = 1'b1; op_i = INST_DIV;
        reg1_rdata_i = 32'd50; reg2_rdata_i = 32'd7; reg_waddr_i = 5'd3;
        tick();
        idle_inputs();
        repeat (5) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (dif.div_start_o !== 1'b0 || hold_o !== 1'b0
            || reg_we_o !== 1'b0 || dif.div_dividend_o !== '0) begin
            errors++;
            $display("FAIL rst_mid got st=%b h=%b we=%b dv=%h want 0 0 0 0",
                     dif.div_start_o, hold_o, reg_we_o,
                     dif.div_dividend_o);
        end
        tick();
        rst = 1'b1;
        run_op("div_50_7", INST_DIV, 32'd50, 32'd7, 5'd3, 32'h7);
    endtask

    initial begin
        test_reset();
        test_ops();
        test_flush();
        test_flush_ready();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/div_issue.md
DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on posedge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req_i  in  1  EX presents a DIV/DIVU/REM/REMU instruction this cycle.
REQ-004 SHALL have ports: op_i  in  3  funct3 code, values `INST_DIV/`INST_DIVU/`INST_REM/`INST_REMU.
REQ-005 SHALL have ports: reg1_rdata_i, reg2_rdata_i  in  32 each  dividend, divisor.
REQ-006 SHALL have ports: reg_waddr_i  in  5  destination register.
REQ-007 SHALL have ports: flush_i  in  1  jump/interrupt kill of the in-flight instruction.
REQ-008 SHALL have ports: div_result_i  in  32, div_ready_i  in  1, div_busy_i  in  1  from divider.
REQ-009 SHALL have ports: div_start_o  out  1, div_dividend_o  out  32, div_divisor_o  out  32, div_op_o  out  3, div_reg_waddr_o  out  5  to divider.
REQ-010 SHALL have ports: hold_o  out  1  pipeline stall request.
REQ-011 SHALL have ports: reg_we_o  out  1, reg_waddr_o  out  5, reg_wdata_o  out  32  writeback port.

Function
REQ-012 SHALL implement states IDLE, WAIT, DONE, CANCEL in a one-hot state register.
REQ-013 IDLE: when req_i=1 and flush_i=0, SHALL capture op, operands, and waddr, then go to WAIT on the next edge.
REQ-014 IDLE: req_i=1 with flush_i=1 SHALL be ignored.
REQ-015 div_start_o SHALL be combinational: 1 only in WAIT with div_ready_i=0 and flush_i=0, so start falls in the same cycle ready is seen and the divider cannot re-launch.
REQ-016 Divider data outputs SHALL be the captured values while in WAIT, and zero otherwise.
REQ-017 WAIT with div_ready_i=1 and flush_i=0: SHALL register div_result_i and go to DONE.
REQ-018 DONE SHALL last exactly one cycle with reg_we_o=1, reg_waddr_o set to the captured waddr, and reg_wdata_o set to the registered result, then go to IDLE.
REQ-019 Outside DONE, reg_we_o SHALL be 0, and reg_waddr_o and reg_wdata_o SHALL be 0.
REQ-020 WAIT with flush_i=1 SHALL go to CANCEL with no writeback; flush wins over a simultaneous div_ready_i and the result is discarded.
REQ-021 CANCEL SHALL hold div_start_o=0 until div_busy_i=0, then go to IDLE; a req_i arriving during CANCEL is not captured.
REQ-022 hold_o SHALL be 1 in WAIT.
REQ-023 hold_o SHALL be 1 in IDLE when req_i=1 and flush_i=0.
REQ-024 hold_o SHALL be 1 in CANCEL when req_i=1.
REQ-025 hold_o SHALL be 0 in all other cases, including DONE.
REQ-026 Latency SHALL be one cycle from req_i to div_start_o, plus the divider latency, plus one cycle from div_ready_i to reg_we_o.
REQ-027 The block SHALL perform no arithmetic; sign handling and divide-by-zero results come from the divider unchanged.
REQ-028 Back-to-back requests SHALL be supported: a new req_i may be captured in the IDLE cycle immediately after DONE.

Reset
REQ-029 rst=0 SHALL force IDLE asynchronously and clear all captured registers and outputs to 0.
REQ-030 rst asserted in WAIT SHALL drop div_start_o immediately; the divider then returns to idle on its own.
REQ-031 On release of rst, the first capture SHALL be possible on the first posedge.

Structure
REQ-032 `INST_DIV..`INST_REMU, `RegBus, `RegAddrBus, `ZeroWord, and state encodings SHALL live in the shared defines file.
REQ-033 There SHALL be no sub-module; div_issue is instantiated next to div, with div_start_o driving start_i and div_ready_i taken from ready_o.

Verification
REQ-034 DIV 7/2 to x5 -> single reg_we_o pulse, waddr 5, wdata 0x00000003; hold_o high from the req cycle until the cycle before the we pulse.
REQ-035 REM -7,2 -> wdata 0xFFFFFFFF; DIVU 9/0 -> wdata 0xFFFFFFFF; REMU 9/0 -> wdata 0x00000009.
REQ-036 flush_i pulsed 10 cycles into WAIT -> no writeback; div_start_o low the same cycle; CANCEL held until div_busy_i=0; next DIV 8/4 -> wdata 0x2.
REQ-037 flush_i and div_ready_i in the same cycle -> no reg_we_o; state returns to IDLE.
REQ-038 Two consecutive DIVU requests (100/10, 50/5) -> two we pulses with 0xA then 0xA; the divider never sees start high in the cycle its ready_o is high.
REQ-039 rst low mid-WAIT -> div_start_o, hold_o, and reg_we_o are 0 asynchronously; after release, a normal DIV completes correctly.
